// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder slice per clock, LSB first,
// with a start/done handshake and registered sum, carry-out and signed overflow.
`timescale 1ns/1ps
module serial_adder_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_sh_next;
    logic             c;
    logic             c_next;
    logic             s_bit;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             busy_next;
    logic             done_next;

    // Single full-adder slice on the current LSBs and the carry flop
    always_comb begin
        s_bit     = a_sh[0] ^ b_sh[0] ^ c;
        c_next    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        r_sh_next = (r_sh >> 1) | {s_bit, {(WIDTH-1){1'b0}}};
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the upcoming state
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // Operand shift registers, carry, counter and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= sub ? ~b : b;
                        r_sh <= '0;
                        c    <= sub;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_sh_next;
                    c    <= c_next;
                    cnt  <= cnt + CW'(1);
                    // Carry into the MSB versus carry out of it gives signed overflow
                    if (last_bit) begin
                        sum       <= r_sh_next;
                        carry_out <= c_next;
                        overflow  <= c ^ c_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
- Parametrised bit-serial adder/subtractor with a start/done handshake.
- Processes two WIDTH-bit operands LSB-first: one full-adder slice per clock, with the carry held in a flip-flop.
- Result is produced after WIDTH cycles and includes sum, carry-out and signed overflow.
- Serves as the sequential arithmetic unit in the lab datapath; it trades latency for a single-bit adder slice.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2 to 64.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request to begin an operation; sampled only in IDLE.
- sub  input  1  operation select, sampled with start: 0 = a+b, 1 = a-b.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse: results are valid.
- sum  output  WIDTH  result bits (a+b or a-b, modulo 2^WIDTH).
- carry_out  output  1  final carry. Add: unsigned carry. Sub: 1 = no borrow (a >= b unsigned).
- overflow  output  1  two's-complement signed overflow of the operation.

Behaviour:
- All state is registered; outputs come directly from flops.
- Reset (rst_n=0 at a clock edge):
  - state to IDLE.
  - busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Reset wins over every other event, including mid-RUN. The in-flight operation is discarded; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - Load A shift register with a.
  - Load B shift register with (sub ? ~b : b).
  - Carry flop = sub; bit counter = 0.
  - Go to RUN.
- IDLE, start=0: remain; sum, carry_out and overflow hold their last values.
- RUN, each edge:
  - s = a_sh[0] ^ b_sh[0] ^ c.
  - c_next = majority(a_sh[0], b_sh[0], c).
  - Shift a_sh and b_sh right by one; shift the result register right, inserting s at bit WIDTH-1.
  - c = c_next; counter increments.
  - On the edge processing bit WIDTH-1:
    - capture overflow = c (carry into the MSB) XOR c_next.
    - capture carry_out = c_next.
    - commit the full result to sum.
    - go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- sum/carry_out/overflow update only at the RUN-to-DONE edge; they are stable from the done cycle until the next completion.
- Latency: start sampled at edge E0; busy=1 during the WIDTH cycles following E0; done=1 in the cycle after edge E_WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while RUN or DONE: ignored. Operands are not re-sampled and no queuing takes place.
- Changes on a, b or sub after E0 have no effect on the current operation.
- Bit counter width: clog2(WIDTH+1). The counter never wraps in normal operation.
- busy and done are never high together.

Test Plan:
- WIDTH=8, add 0x0F+0x01 -> sum=0x10, carry_out=0, overflow=0. busy high for 8 cycles; done pulses exactly 9 cycles after the start edge, for one cycle.
- Add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0. Add 0x7F+0x01 -> sum=0x80, carry_out=0, overflow=1.
- Subtract 0x05-0x07 -> sum=0xFE, carry_out=0 (borrow), overflow=0. Subtract 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1.
- Pulse start with different operands at cycle 3 of RUN -> ignored; the original result is delivered. Operands are changed during RUN with no effect. A new start one cycle after done is accepted.
- Assert rst_n=0 at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, carry_out=0, overflow=0. No done pulse follows; a subsequent 0x03+0x04 returns 0x07.
- WIDTH=16 instance, random sweep of 1000 add/sub operations against a reference model (a±b mod 2^16, carry, signed overflow) -> zero mismatches; done always 17 cycles after start.
